fp_regfile: RTL

FP_REGFILE -- requirements
Module: fp_regfile

---
 rtl/fp_regfile_pkg.sv | 17 +
 rtl/fp_scoreboard.sv | 76 +++++++
 rtl/fp_regfile.sv | 94 +++++++++
 3 files changed

// File: rtl/fp_regfile_pkg.sv
// ---------------------------------------------------------------------------
// fp_regfile_pkg
// Shared CPU constants for the floating-point register file and its
// load-use scoreboard: register count, register width, register-index
// width and the value every FP register takes while reset is held.
// ---------------------------------------------------------------------------
package fp_regfile_pkg;

   localparam int FP_NREG = 32;
   localparam int FP_XLEN = 32;
   localparam int FP_AW   = 5;

   localparam logic [FP_XLEN-1:0] FP_RESET_VAL = 32'h0000_0000;

   typedef logic [FP_AW-1:0] fp_idx_t;

endpackage

// File: rtl/fp_scoreboard.sv
// ---------------------------------------------------------------------------
// fp_scoreboard
// One pending bit per FP register, marking a destination whose long-latency
// producer (FLW) is still in flight, plus the decode stall compare.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   pend_set, pend_addr   producer issued this cycle; marks pend_addr pending
//   we, rd_addr           writeback; clears the pending bit of rd_addr
//   kill, kill_addr       flushed producer; clears the pending bit of kill_addr
//   rs1_addr, rs2_addr    decode read addresses
//   use1, use2            decode actually reads the FP operand on that port
//   bypass1, bypass2      the writeback this cycle supplies that port
//   stall                 an operand that decode needs is not available yet
//   pend_vec              registered pending bits
// ---------------------------------------------------------------------------
module fp_scoreboard
   import fp_regfile_pkg::*;
#(
   parameter int NREG = FP_NREG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pend_set,
   input  logic [FP_AW-1:0] pend_addr,
   input  logic             we,
   input  logic [FP_AW-1:0] rd_addr,
   input  logic             kill,
   input  logic [FP_AW-1:0] kill_addr,
   input  logic [FP_AW-1:0] rs1_addr,
   input  logic [FP_AW-1:0] rs2_addr,
   input  logic             use1,
   input  logic             use2,
   input  logic             bypass1,
   input  logic             bypass2,
   output logic             stall,
   output logic [NREG-1:0]  pend_vec
);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   // Set and clear are built as independent one-hot masks so that a set on
   // one index and a clear on another both land on the same edge. Applying
   // the set after the clear makes a new producer win over a retiring one
   // that targets the same register.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (pend_set) set_mask = set_mask | (NREG'(1) << pend_addr);
      if (we)       clr_mask = clr_mask | (NREG'(1) << rd_addr);
      if (kill)     clr_mask = clr_mask | (NREG'(1) << kill_addr);
   end

   // Pending bits: cleared asynchronously so a reset wipes the scoreboard
   // without waiting for a clock, and nothing issued under reset survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~clr_mask) | set_mask;
      end
   end

   // The stall looks only at registered pending bits. A producer issued in
   // this same cycle is caught by the EX/MEM hazard check instead, and a
   // writeback arriving this cycle releases its consumer through the bypass.
   always_comb begin
      stall = (use1 & pend_q[rs1_addr] & ~bypass1) |
              (use2 & pend_q[rs2_addr] & ~bypass2);
   end

   assign pend_vec = pend_q;

endmodule

// File: rtl/fp_regfile.sv
// ---------------------------------------------------------------------------
// fp_regfile
// Floating-point register file f0..f31 (f0 is an ordinary register) with two
// combinational read ports, one write port with write-through bypass, and a
// load-use scoreboard that stalls decode on operands still in flight.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   rs1_addr, rs2_addr     read addresses (ALU operand1 / operand2)
//   use1, use2             decoded instruction reads that FP operand
//   rs1_data, rs2_data     read data, zero-cycle latency
//   we, rd_addr, rd_data   writeback port
//   pend_set, pend_addr    long-latency producer issued, destination index
//   kill, kill_addr        flushed producer, destination index
//   stall                  hold decode
//   pend_vec               registered scoreboard bits
// ---------------------------------------------------------------------------
module fp_regfile
   import fp_regfile_pkg::*;
#(
   parameter int NREG = FP_NREG,
   parameter int XLEN = FP_XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FP_AW-1:0] rs1_addr,
   input  logic [FP_AW-1:0] rs2_addr,
   input  logic             use1,
   input  logic             use2,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   input  logic             we,
   input  logic [FP_AW-1:0] rd_addr,
   input  logic [XLEN-1:0]  rd_data,
   input  logic             pend_set,
   input  logic [FP_AW-1:0] pend_addr,
   input  logic             kill,
   input  logic [FP_AW-1:0] kill_addr,
   output logic             stall,
   output logic [NREG-1:0]  pend_vec
);

   logic [XLEN-1:0] regs [NREG];
   logic            bypass1;
   logic            bypass2;

   // Register storage. Writes presented while reset is held are lost on
   // purpose; nothing is replayed after reset releases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= XLEN'(FP_RESET_VAL);
         end
      end else if (we) begin
         regs[rd_addr] <= rd_data;
      end
   end

   // Write-through bypass: a port reading the register being written this
   // cycle sees the new value immediately. Reset forces both ports to the
   // reset constant so a write attempted during reset is never visible.
   always_comb begin
      bypass1  = we & (rd_addr == rs1_addr);
      bypass2  = we & (rd_addr == rs2_addr);
      rs1_data = bypass1 ? rd_data : regs[rs1_addr];
      rs2_data = bypass2 ? rd_data : regs[rs2_addr];
      if (rst) begin
         rs1_data = XLEN'(FP_RESET_VAL);
         rs2_data = XLEN'(FP_RESET_VAL);
      end
   end

   fp_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .pend_set  (pend_set),
      .pend_addr (pend_addr),
      .we        (we),
      .rd_addr   (rd_addr),
      .kill      (kill),
      .kill_addr (kill_addr),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .use1      (use1),
      .use2      (use2),
      .bypass1   (bypass1),
      .bypass2   (bypass2),
      .stall     (stall),
      .pend_vec  (pend_vec)
   );

endmodule
